// File: rtl/serial_subtractor_pkg.sv
// sub_pkg: shared state encodings and counter sizing for the serial subtractor
package sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: parallel-side start/busy/done handshake and operand/result bus
interface serial_subtractor_if #(parameter int WIDTH = 8);

    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_bin;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_bout;

    modport master (
        output i_start, i_a, i_b, i_bin,
        input  o_busy, o_done, o_diff, o_bout
    );

    modport slave (
        input  i_start, i_a, i_b, i_bin,
        output o_busy, o_done, o_diff, o_bout
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit combinational subtract cell (a - b - bin)
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    assign o_diff = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - bin, LSB first, one bit per RUN cycle
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic               i_clk,
    input logic               i_rst,
    serial_subtractor_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic             d;
    logic             bo;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;

    assign accept = (state == ST_IDLE) && bus.i_start;
    assign last   = (cnt == CW'(WIDTH - 1));

    full_subtractor u_cell (
        .i_a   (a_sr[0]),
        .i_b   (b_sr[0]),
        .i_bin (br),
        .o_diff(d),
        .o_bout(bo)
    );

    // Next state; the unused encoding falls back to IDLE
    always_comb begin
        state_nx = accept ? ST_RUN :
                   (state == ST_RUN) ? (last ? ST_DONE : ST_RUN) :
                   ST_IDLE;
    end

    // State, operand/result shift registers, borrow and bit counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            d_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sr <= bus.i_a;
                b_sr <= bus.i_b;
                br   <= bus.i_bin;
                cnt  <= '0;
            end else if (state == ST_RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                d_sr <= {d, d_sr[WIDTH-1:1]};
                br   <= bo;
                cnt  <= last ? cnt : cnt + CW'(1);
            end
        end
    end

    assign bus.o_busy = (state == ST_RUN);
    assign bus.o_done = (state == ST_DONE);
    assign bus.o_diff = d_sr;
    assign bus.o_bout = br;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor at WIDTH=4
module tb_serial_subtractor;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.WIDTH(W)) sub ();

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (sub)
    );

    always #5 clk = ~clk;

    // busy and done must never overlap
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (sub.o_busy && sub.o_done) begin
                errors++;
                $display("FAIL busy_done_overlap busy=%0b done=%0b required not both", sub.o_busy, sub.o_done);
            end
        end
    end

    function automatic int model_diff(input int a, input int b, input int bi);
        return (a - b - bi) & ((1 << W) - 1);
    endfunction

    function automatic int model_bout(input int a, input int b, input int bi);
        return (a < b + bi) ? 1 : 0;
    endfunction

    // one accepted operation from IDLE; returns at the first IDLE negedge after done
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         output logic [W-1:0] d, output logic bo, output int lat, output int busy_n);
        sub.i_a     = a;
        sub.i_b     = b;
        sub.i_bin   = bi;
        sub.i_start = 1'b1;
        @(negedge clk);
        sub.i_start = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!sub.o_done && lat < 20) begin
            if (sub.o_busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        d  = sub.o_diff;
        bo = sub.o_bout;
        if (!sub.o_done) lat = -1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        sub.i_start = 1'b0;
        sub.i_a     = '0;
        sub.i_b     = '0;
        sub.i_bin   = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sub.o_busy, sub.o_done, sub.o_diff, sub.o_bout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%0b done=%0b diff=%0h bout=%0b required all 0",
                     sub.o_busy, sub.o_done, sub.o_diff, sub.o_bout);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] d;
        logic         bo;
        int           lat, busy_n;
        int           vec[4][3] = '{'{9, 3, 0}, '{3, 9, 0}, '{0, 0, 1}, '{8, 7, 1}};
        for (int i = 0; i < 4; i++) begin
            do_op(W'(vec[i][0]), W'(vec[i][1]), vec[i][2][0], d, bo, lat, busy_n);
            checks++;
            if (lat !== W + 1) begin
                errors++;
                $display("FAIL directed_latency op=%0d got=%0d required=%0d", i, lat, W + 1);
            end
            checks++;
            if (busy_n !== W) begin
                errors++;
                $display("FAIL directed_busy_cycles op=%0d got=%0d required=%0d", i, busy_n, W);
            end
            checks++;
            if (d !== W'(model_diff(vec[i][0], vec[i][1], vec[i][2]))) begin
                errors++;
                $display("FAIL directed_diff op=%0d got=%0h required=%0h", i, d,
                         model_diff(vec[i][0], vec[i][1], vec[i][2]));
            end
            checks++;
            if (bo !== model_bout(vec[i][0], vec[i][1], vec[i][2])) begin
                errors++;
                $display("FAIL directed_bout op=%0d got=%0b required=%0d", i, bo,
                         model_bout(vec[i][0], vec[i][1], vec[i][2]));
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, d;
        logic         bi, bo;
        int           lat, busy_n;
        for (int i = 0; i < 24; i++) begin
            a  = W'($urandom_range(0, (1 << W) - 1));
            b  = W'($urandom_range(0, (1 << W) - 1));
            bi = 1'($urandom_range(0, 1));
            do_op(a, b, bi, d, bo, lat, busy_n);
            checks++;
            if (lat !== W + 1 || d !== W'(model_diff(a, b, bi)) || bo !== model_bout(a, b, bi)) begin
                errors++;
                $display("FAIL random_op a=%0h b=%0h bin=%0b got diff=%0h bout=%0b lat=%0d required diff=%0h bout=%0d lat=%0d",
                         a, b, bi, d, bo, lat, model_diff(a, b, bi), model_bout(a, b, bi), W + 1);
            end
        end
    endtask

    task automatic test_ignored_start();
        int           dones = 0;
        logic [W-1:0] d = '0;
        logic         bo = 1'b0;
        sub.i_a     = W'(5);
        sub.i_b     = W'(1);
        sub.i_bin   = 1'b0;
        sub.i_start = 1'b1;
        @(negedge clk);
        sub.i_start = 1'b0;
        @(negedge clk);
        sub.i_a     = W'(1);
        sub.i_b     = W'(5);
        sub.i_start = 1'b1;
        @(negedge clk);
        sub.i_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (sub.o_done) begin
                dones++;
                d  = sub.o_diff;
                bo = sub.o_bout;
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignored_start_dones got=%0d required=1", dones);
        end
        checks++;
        if (d !== W'(4) || bo !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_result got diff=%0h bout=%0b required diff=4 bout=0", d, bo);
        end
    endtask

    task automatic test_reset_mid_run();
        int           dones = 0;
        logic [W-1:0] d;
        logic         bo;
        int           lat, busy_n;
        sub.i_a     = W'(12);
        sub.i_b     = W'(3);
        sub.i_bin   = 1'b1;
        sub.i_start = 1'b1;
        @(negedge clk);
        sub.i_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({sub.o_busy, sub.o_done, sub.o_diff, sub.o_bout} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run_outputs busy=%0b done=%0b diff=%0h bout=%0b required all 0",
                     sub.o_busy, sub.o_done, sub.o_diff, sub.o_bout);
        end
        for (int i = 0; i < 10; i++) begin
            if (sub.o_done || sub.o_busy) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_mid_run_activity got=%0d busy/done cycles required=0", dones);
        end
        do_op(W'(7), W'(2), 1'b0, d, bo, lat, busy_n);
        checks++;
        if (d !== W'(5) || bo !== 1'b0 || lat !== W + 1) begin
            errors++;
            $display("FAIL reset_then_op got diff=%0h bout=%0b lat=%0d required diff=5 bout=0 lat=%0d", d, bo, lat, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        int order[512];
        int tmp, j, cur, gap;
        for (int i = 0; i < 512; i++) order[i] = i;
        for (int i = 511; i > 0; i--) begin
            j        = $urandom_range(0, i);
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        cur         = order[0];
        sub.i_a     = W'(cur[3:0]);
        sub.i_b     = W'(cur[7:4]);
        sub.i_bin   = cur[8];
        sub.i_start = 1'b1;
        for (int k = 0; k < 512; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!sub.o_done && gap < 20);
            checks++;
            if (gap !== ((k == 0) ? W + 1 : W + 2)) begin
                errors++;
                $display("FAIL b2b_spacing op=%0d got=%0d required=%0d", k, gap, (k == 0) ? W + 1 : W + 2);
            end
            if (!sub.o_done) break;
            checks++;
            if (sub.o_diff !== W'(model_diff(cur[3:0], cur[7:4], cur[8])) ||
                sub.o_bout !== model_bout(cur[3:0], cur[7:4], cur[8])) begin
                errors++;
                $display("FAIL b2b_result a=%0h b=%0h bin=%0b got diff=%0h bout=%0b required diff=%0h bout=%0d",
                         cur[3:0], cur[7:4], cur[8], sub.o_diff, sub.o_bout,
                         model_diff(cur[3:0], cur[7:4], cur[8]), model_bout(cur[3:0], cur[7:4], cur[8]));
            end
            if (k < 511) begin
                cur       = order[k + 1];
                sub.i_a   = W'(cur[3:0]);
                sub.i_b   = W'(cur[7:4]);
                sub.i_bin = cur[8];
            end
        end
        sub.i_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
